// File: rtl/cookie_pkg.sv
// Shared definitions for the cookie sequencer: FSM state encoding and
// the random-bit LFSR constants.
package cookie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Feedback taps b0, b2, b3, b5 (x^16+x^14+x^13+x^11+1).
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

endpackage

// File: rtl/cookie_lfsr.sv
// Fibonacci right-shifting LFSR that supplies random bits to the crumb array.
// A zero seed is replaced by the default seed so the register never locks up.
module cookie_lfsr
  import cookie_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic         bit_o
);

  localparam logic [W-1:0] DEF_SEED = W'(LFSR_DEFAULT_SEED);
  localparam logic [W-1:0] TAPS     = W'(LFSR_TAP_MASK);

  logic [W-1:0] q;
  logic         fb;

  assign fb    = ^(q & TAPS);
  assign bit_o = q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= DEF_SEED;
    end else if (load) begin
      q <= (seed == '0) ? DEF_SEED : seed;
    end else if (step) begin
      q <= {fb, q[W-1:1]};
    end
  end

endmodule

// File: rtl/cookie_sequencer.sv
// Frame sequencer for the crumb array: array reset, a run of random bits,
// a drain of zero bits, then a one-cycle done pulse.
module cookie_sequencer
  import cookie_pkg::*;
#(
  parameter int LFSR_W      = 16,
  parameter int CHAIN_DEPTH = 16,
  parameter int LEN_W       = 8,
  parameter int ARST_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LEN_W-1:0]  run_len,
  output logic              arr_rst_n,
  output logic              arr_en,
  output logic              arr_rbit,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bits_sent
);

  localparam int CNT_MAX = (CHAIN_DEPTH > ARST_CYC) ? CHAIN_DEPTH : ARST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   run_len_q;
  logic               lfsr_bit;
  logic               lfsr_load;
  logic               lfsr_step;

  assign lfsr_load = (state == ST_IDLE) && seed_load;
  assign lfsr_step = (state == ST_RUN) && !abort;

  cookie_lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .bit_o(lfsr_bit)
  );

  // Outputs are registered decodes of the state held during the previous
  // cycle, which is what adds the leading cycle to the frame latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run_len_q <= '0;
      bits_sent <= '0;
      arr_rst_n <= 1'b0;
      arr_en    <= 1'b0;
      arr_rbit  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      arr_rst_n <= 1'b1;
      arr_en    <= 1'b0;
      arr_rbit  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      arr_rst_n <= (state != ST_ARST);
      arr_en    <= (state == ST_RUN) || (state == ST_DRAIN);
      arr_rbit  <= (state == ST_RUN) && lfsr_bit;
      busy      <= (state != ST_IDLE);
      done      <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state     <= ST_ARST;
            run_len_q <= run_len;
            bits_sent <= '0;
            cnt       <= '0;
          end
        end
        ST_ARST: begin
          if (cnt == CNT_W'(ARST_CYC - 1)) begin
            cnt   <= '0;
            state <= (run_len_q != '0) ? ST_RUN : ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bits_sent != run_len_q) begin
            bits_sent <= bits_sent + 1'b1;
          end
          if ((bits_sent + LEN_W'(1)) == run_len_q) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt == CNT_W'(CHAIN_DEPTH - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cookie_sequencer.sv
// Directed bench for cookie_sequencer: frame timing, random-bit stream,
// abort, reset, seed handling and ignored starts.
module tb_cookie_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        seed_load;
  logic [15:0] seed;
  logic [7:0]  run_len;
  logic        arr_rst_n;
  logic        arr_en;
  logic        arr_rbit;
  logic        busy;
  logic        done;
  logic [7:0]  bits_sent;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cookie_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .seed_load(seed_load),
    .seed     (seed),
    .run_len  (run_len),
    .arr_rst_n(arr_rst_n),
    .arr_en   (arr_en),
    .arr_rbit (arr_rbit),
    .busy     (busy),
    .done     (done),
    .bits_sent(bits_sent)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Runs one frame starting at the next edge. Cycle k counts edges after
  // the start-sample edge; outputs are checked 1 time unit after edge k.
  task automatic frame(input int rl, input logic [15:0] sd, input bit do_load,
                       input bit pulse_start, input int abort_at, input string tag);
    logic [15:0] s;
    int          done_cnt;
    int          held;
    bit          aborted;
    int          e_rst_n, e_en, e_rbit, e_busy, e_done, e_bits;
    check({tag, " idle_before"}, busy, 0);
    s         = (sd == 16'h0) ? 16'hACE1 : sd;
    seed      = sd;
    seed_load = do_load;
    start     = 1'b1;
    run_len   = rl[7:0];
    step();
    seed_load = 1'b0;
    start     = 1'b0;
    run_len   = ~rl[7:0];
    done_cnt  = 0;
    aborted   = 1'b0;
    held      = 0;
    for (int k = 1; k <= rl + 21; k++) begin
      if (pulse_start && (k == 4 || k == rl + 10)) start = 1'b1;
      if (abort_at > 0 && k == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
        held    = (k - 3 < rl) ? k - 3 : rl;
      end
      step();
      start = 1'b0;
      abort = 1'b0;
      if (aborted) begin
        e_rst_n = 1; e_en = 0; e_rbit = 0; e_busy = 0; e_done = 0; e_bits = held;
      end else begin
        e_rst_n = (k == 1 || k == 2) ? 0 : 1;
        e_en    = (k >= 3 && k <= rl + 18) ? 1 : 0;
        e_rbit  = 0;
        if (k >= 3 && k <= rl + 2) begin
          e_rbit = s[0];
          s      = lfsr_next(s);
        end
        e_done = (k == rl + 19) ? 1 : 0;
        e_busy = (k >= 1 && k <= rl + 19) ? 1 : 0;
        e_bits = (k < 3) ? 0 : ((k - 2 < rl) ? k - 2 : rl);
      end
      if (done) done_cnt++;
      check($sformatf("%s k=%0d arr_rst_n", tag, k), arr_rst_n, e_rst_n);
      check($sformatf("%s k=%0d arr_en", tag, k), arr_en, e_en);
      check($sformatf("%s k=%0d arr_rbit", tag, k), arr_rbit, e_rbit);
      check($sformatf("%s k=%0d busy", tag, k), busy, e_busy);
      check($sformatf("%s k=%0d done", tag, k), done, e_done);
      check($sformatf("%s k=%0d bits_sent", tag, k), bits_sent, e_bits);
    end
    check({tag, " done_pulses"}, done_cnt, (abort_at > 0) ? 0 : 1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0;
    run_len   = 8'h0;
    step();
    step();
    check("rst arr_rst_n", arr_rst_n, 0);
    check("rst arr_en", arr_en, 0);
    check("rst arr_rbit", arr_rbit, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bits_sent", bits_sent, 0);
    rst = 1'b0;
    step();
    check("post_rst arr_rst_n", arr_rst_n, 1);

    // Basic frame, seed loaded together with start.
    frame(4, 16'hACE1, 1'b1, 1'b0, 0, "len4");
    // LFSR persists: four steps from ACE1 leave 2ACE.
    frame(3, 16'h2ACE, 1'b0, 1'b0, 0, "persist");
    frame(0, 16'hACE1, 1'b1, 1'b0, 0, "len0");
    frame(8, 16'hACE1, 1'b1, 1'b0, 5, "abort");
    frame(16, 16'h0000, 1'b1, 1'b0, 0, "seed0");
    frame(5, 16'h1234, 1'b1, 1'b1, 0, "ignore_start");

    // Abort together with start in IDLE: nothing starts.
    abort = 1'b1;
    start = 1'b1;
    run_len = 8'd3;
    step();
    abort = 1'b0;
    start = 1'b0;
    step();
    check("idle_abort busy", busy, 0);
    check("idle_abort arr_rst_n", arr_rst_n, 1);

    // Reset during DRAIN of a run_len=2 frame.
    seed_load = 1'b1;
    seed      = 16'h5A5A;
    start     = 1'b1;
    run_len   = 8'd2;
    step();
    seed_load = 1'b0;
    start     = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    check("drain_rst pre arr_en", arr_en, 1);
    rst = 1'b1;
    step();
    check("drain_rst arr_rst_n", arr_rst_n, 0);
    check("drain_rst arr_en", arr_en, 0);
    check("drain_rst arr_rbit", arr_rbit, 0);
    check("drain_rst busy", busy, 0);
    check("drain_rst done", done, 0);
    check("drain_rst bits_sent", bits_sent, 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("drain_rst after k=%0d done", k), done, 0);
      check($sformatf("drain_rst after k=%0d busy", k), busy, 0);
    end
    // Reset restores the default seed.
    frame(4, 16'hACE1, 1'b0, 1'b0, 0, "post_rst_seed");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cookie_sequencer.md
COOKIE_SEQUENCER -- requirements
Module: cookie_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LFSR_W, 16, random-bit LFSR width; CHAIN_DEPTH, 16, crumb-array depth in cycles used for drain; LEN_W, 8, run-length counter width; ARST_CYC, 2, array-reset hold cycles.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin a frame; sampled only in IDLE.
REQ-006 abort  in  1  terminate any frame; returns to IDLE.
REQ-007 seed_load  in  1  load seed into LFSR; honoured only in IDLE.
REQ-008 seed  in  LFSR_W  LFSR seed value.
REQ-009 run_len  in  LEN_W  number of random bits per frame; latched at start.
REQ-010 arr_rst_n  out  1  active-low reset to the crumb array.
REQ-011 arr_en  out  1  enable to the crumb array.
REQ-012 arr_rbit  out  1  random bit to the crumb array.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at normal frame completion.
REQ-015 bits_sent  out  LEN_W  random bits issued in the current/last frame.

Function
REQ-016 FSM states SHALL be IDLE, ARST, RUN, DRAIN, DONE; all outputs registered.
REQ-017 IDLE: arr_rst_n=1, arr_en=0, arr_rbit=0; start=1 -> ARST, latch run_len, clear bits_sent.
REQ-018 ARST: arr_rst_n=0, arr_en=0 for exactly ARST_CYC cycles; then RUN if latched run_len!=0, else DRAIN.
REQ-019 RUN: arr_en=1, arr_rbit=LFSR bit 0; LFSR advances and bits_sent increments each cycle; exactly run_len cycles, then DRAIN.
REQ-020 DRAIN: arr_en=1, arr_rbit=0 for exactly CHAIN_DEPTH cycles; LFSR holds; then DONE.
REQ-021 DONE: arr_en=0, done=1 for one cycle; then IDLE.
REQ-022 LFSR: Fibonacci, shift right, new MSB = b0^b2^b3^b5 (x^16+x^14+x^13+x^11+1 for LFSR_W=16).
REQ-023 Seed value 0 SHALL be replaced by 16'hACE1 (lockup avoidance); LFSR state persists across frames unless reloaded.
REQ-024 seed_load and start in the same IDLE cycle: seed loads first; frame uses the new seed.
REQ-025 start while busy SHALL be ignored; run_len changes after start SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state: next cycle IDLE, arr_en=0, arr_rst_n=1, no done pulse, bits_sent holds its value; abort has priority over all other transitions.
REQ-027 abort and start together in IDLE: start is ignored.
REQ-028 bits_sent SHALL saturate at run_len; it never wraps.
REQ-029 Frame latency start->done SHALL be 1+ARST_CYC+run_len+CHAIN_DEPTH cycles (done asserted that many cycles after the start sample edge).

Reset
REQ-030 rst=1 SHALL force IDLE, arr_rst_n=0, arr_en=0, arr_rbit=0, busy=0, done=0, bits_sent=0, LFSR=16'hACE1, all counters 0.
REQ-031 First cycle after rst release SHALL drive arr_rst_n=1.
REQ-032 rst mid-frame SHALL behave as REQ-030, with no done pulse.

Structure
REQ-033 A shared package cookie_pkg SHALL hold the FSM state enum, LFSR default seed 16'hACE1, and the tap mask.
REQ-034 The LFSR SHALL be one sub-module, cookie_lfsr (ports: clk, rst, load, seed, step, bit_o); the FSM and counters stay in cookie_sequencer.

Verification
REQ-035 Reset, seed_load seed=16'hACE1, start run_len=4 -> arr_rst_n low 2 cycles, arr_en high 4+16 cycles, arr_rbit = 1,0,0,0 then 0s, done at cycle 23, bits_sent=4.
REQ-036 start with run_len=0 -> ARST 2 cycles, DRAIN 16 cycles, no RUN, done at cycle 19, bits_sent=0.
REQ-037 run_len=8, abort asserted on 3rd RUN cycle -> IDLE next cycle, arr_en=0, no done, bits_sent=2.
REQ-038 seed_load seed=0 then run_len=16 -> bit stream identical to seed=16'hACE1 run.
REQ-039 start pulses during RUN and DRAIN of a run_len=5 frame -> ignored, exactly one done pulse, busy low after it.
REQ-040 rst asserted during DRAIN -> next cycle all outputs at REQ-030 values, done never pulses.
